// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side frame controller for the UART RX path. Detects a start bit on
// the oversampled serial line, tracks the edge index within each bit and the
// data-bit index, and issues one-cycle check/shift strobes to the sampler,
// deserializer and start/parity/stop checkers. A one-cycle data_valid pulse
// flags a frame that finished with no parity or stop error.
//
// Ports:
//   clk          RX oversampling clock
//   rst          asynchronous active-low reset
//   rx_in        serial line, idle high, already synchronized
//   prescale     oversampling ratio (even, 8..32), latched at frame start
//   par_en       frame carries a parity bit, latched at frame start
//   par_err      registered parity-checker result (held until next check)
//   strt_glitch  registered start-checker result
//   stp_err      registered stop-checker result
//   dat_samp_en  data sampler enable (high whenever a frame is in progress)
//   edge_cnt     edge index within the current bit, 0..prescale-1
//   bit_cnt      data-bit index, 0..Data_Width-1
//   deser_en     deserializer shift strobe
//   strt_chk_en  start-check strobe
//   par_chk_en   parity-check strobe
//   stp_chk_en   stop-check strobe
//   data_valid   one-cycle pulse, frame error-free
//   busy         high in any state other than IDLE
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int Data_Width = 8,
  parameter int Pre_Width  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [Pre_Width-1:0] prescale,
  input  logic                 par_en,
  input  logic                 par_err,
  input  logic                 strt_glitch,
  input  logic                 stp_err,
  output logic                 dat_samp_en,
  output logic [Pre_Width-1:0] edge_cnt,
  output logic [3:0]           bit_cnt,
  output logic                 deser_en,
  output logic                 strt_chk_en,
  output logic                 par_chk_en,
  output logic                 stp_chk_en,
  output logic                 data_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ERR_CHK
  } state_e;

  localparam logic [3:0] LastBit = 4'(Data_Width - 1);

  state_e               state_q,    state_d;
  logic [Pre_Width-1:0] edge_q,     edge_d;
  logic [3:0]           bit_q,      bit_d;
  logic [Pre_Width-1:0] pre_q,      pre_d;
  logic                 par_en_q,   par_en_d;

  logic [Pre_Width-1:0] last_edge;
  logic [Pre_Width-1:0] chk_edge;
  logic                 at_last;
  logic                 at_chk;

  // Checks happen one edge after the three majority samples at P/2-1..P/2+1.
  assign last_edge = pre_q - Pre_Width'(1);
  assign chk_edge  = (pre_q >> 1) + Pre_Width'(2);
  assign at_last   = (edge_q == last_edge);
  assign at_chk    = (edge_q == chk_edge);

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    edge_d   = at_last ? '0 : edge_q + Pre_Width'(1);
    bit_d    = bit_q;
    pre_d    = pre_q;
    par_en_d = par_en_q;

    unique case (state_q)
      S_IDLE: begin
        edge_d = '0;
        // The detection cycle is edge 0, so START opens on edge 1.
        if (!rx_in) begin
          state_d  = S_START;
          edge_d   = Pre_Width'(1);
          pre_d    = prescale;
          par_en_d = par_en;
        end
      end
      S_START: begin
        if (at_last) begin
          if (strt_glitch) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (at_last) begin
          if (bit_q == LastBit) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (at_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_last) state_d = S_ERR_CHK;
      end
      S_ERR_CHK: begin
        // A low line here is the next start bit; this cycle is its edge 0.
        if (!rx_in) begin
          state_d  = S_START;
          edge_d   = Pre_Width'(1);
          pre_d    = prescale;
          par_en_d = par_en;
        end else begin
          state_d = S_IDLE;
          edge_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      pre_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      pre_q    <= pre_d;
      par_en_q <= par_en_d;
    end
  end

  // Outputs come only from registered state/counters; the checker results
  // feed data_valid but rx_in never reaches an output.
  always_comb begin
    busy        = (state_q != S_IDLE);
    dat_samp_en = busy;
    edge_cnt    = edge_q;
    bit_cnt     = bit_q;
    strt_chk_en = (state_q == S_START)  && at_chk;
    deser_en    = (state_q == S_DATA)   && at_chk;
    par_chk_en  = (state_q == S_PARITY) && at_chk;
    stp_chk_en  = (state_q == S_STOP)   && at_chk;
    data_valid  = (state_q == S_ERR_CHK) && !((par_err && par_en_q) || stp_err);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Frame-level bench for uart_rx_ctrl. The stimulus task drives whole UART
// frames and, from the frame parameters alone, pushes the expected strobe /
// data_valid events (kind + absolute cycle) into a queue. A monitor pops that
// queue whenever the DUT raises a strobe or data_valid. Busy, edge_cnt and
// bit_cnt are compared every cycle against values derived from the cycle
// offset within the frame. The checkers downstream are modelled as registers
// that capture a configured result on their strobe and hold it.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          par_en = 1'b0;
  logic          par_err = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          stp_err = 1'b0;
  logic          dat_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          deser_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          data_valid;
  logic          busy;

  uart_rx_ctrl #(.Data_Width(DW), .Pre_Width(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_err     (par_err),
    .strt_glitch (strt_glitch),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_STRT, EV_DESER, EV_PAR, EV_STP, EV_DV} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       at;
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle expectations, written by the stimulus side.
  bit chk_state   = 1'b0;
  bit exp_busy    = 1'b0;
  int exp_edge    = 0;
  bit exp_bit_vld = 1'b0;
  int exp_bit     = 0;

  // Downstream checker behaviour chosen per frame.
  bit cfg_glitch  = 1'b0;
  bit cfg_par_err = 1'b0;
  bit cfg_stp_err = 1'b0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
    end else begin
      if (strt_chk_en) strt_glitch = cfg_glitch;
      if (par_chk_en)  par_err     = cfg_par_err;
      if (stp_chk_en)  stp_err     = cfg_stp_err;
    end
  end

  task automatic match(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL event_unexpected at cycle %0d: got kind %0d, expected no event", cyc, k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_cycle", 32'(cyc), 32'(e.at));
    end
  endtask

  int n_strb;
  always @(negedge clk) begin
    if (rst) begin
      n_strb = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en)
             + int'(stp_chk_en) + int'(data_valid);
      if (n_strb != 0) check("strobe_overlap", 32'(n_strb), 32'd1);
      if (strt_chk_en) match(EV_STRT);
      if (deser_en)    match(EV_DESER);
      if (par_chk_en)  match(EV_PAR);
      if (stp_chk_en)  match(EV_STP);
      if (data_valid)  match(EV_DV);
      if (chk_state) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("dat_samp_en", 32'(dat_samp_en), 32'(exp_busy));
        check("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
        if (exp_bit_vld) check("bit_cnt", 32'(bit_cnt), 32'(exp_bit));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     32'(busy),        32'd0);
    check({tag, "_samp"},     32'(dat_samp_en), 32'd0);
    check({tag, "_edge"},     32'(edge_cnt),    32'd0);
    check({tag, "_bit"},      32'(bit_cnt),     32'd0);
    check({tag, "_strobes"},  32'({deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 32'd0);
    check({tag, "_valid"},    32'(data_valid),  32'd0);
  endtask

  task automatic push_ev(input ev_kind_e k, input int at, input int t0, input int abort_at);
    ev_t e;
    if (abort_at < 0 || (at - t0) < abort_at) begin
      e.kind = k;
      e.at   = at;
      exp_q.push_back(e);
    end
  endtask

  // Drives one frame starting now (called #1 after a rising edge; this cycle
  // is the detection cycle). Returns on the cycle after the frame's last edge,
  // i.e. the error-check cycle, or the IDLE cycle after a start glitch.
  task automatic send_frame(input int p, input bit pe, input logic [7:0] data,
                            input bit glitch, input bit perr, input bit serr,
                            input bit first_busy, input int abort_at);
    int nbits = DW + 2 + int'(pe);
    int f     = glitch ? p : p * nbits;
    int t0    = cyc;
    int c     = p / 2 + 2;
    logic [11:0] fb;
    fb = '1;
    fb[0] = 1'b0;
    for (int k = 0; k < DW; k++) fb[1 + k] = data[k];
    if (pe) fb[DW + 1] = ^data;
    cfg_glitch  = glitch;
    cfg_par_err = perr;
    cfg_stp_err = serr;
    prescale    = PW'(p);
    par_en      = pe;

    push_ev(EV_STRT, t0 + c, t0, abort_at);
    if (!glitch) begin
      for (int k = 0; k < DW; k++) push_ev(EV_DESER, t0 + p * (k + 1) + c, t0, abort_at);
      if (pe) push_ev(EV_PAR, t0 + p * (DW + 1) + c, t0, abort_at);
      push_ev(EV_STP, t0 + p * (nbits - 1) + c, t0, abort_at);
      if (!((perr && pe) || serr)) push_ev(EV_DV, t0 + f, t0, abort_at);
    end

    for (int t = 0; t < f; t++) begin
      if (t == abort_at) begin
        chk_state = 1'b0;
        rx_in     = 1'b1;
        rst       = 1'b0;
        #1;
        check_all_zero("abort");
        return;
      end
      rx_in = glitch ? (t >= 2) : fb[t / p];
      if (t == 1) begin
        // Mid-frame changes must not disturb the frame in flight.
        prescale = PW'(2 * $urandom_range(4, 16));
        par_en   = ~pe;
      end
      exp_busy    = (t > 0) || first_busy;
      exp_edge    = t % p;
      exp_bit_vld = !glitch && (t >= p) && (t < p * (DW + 1));
      exp_bit     = t / p - 1;
      chk_state   = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  // Line held high; first cycle may be the error-check cycle of a frame.
  task automatic idle(input int n, input bit first_errchk);
    for (int k = 0; k < n; k++) begin
      rx_in       = 1'b1;
      exp_busy    = (k == 0) && first_errchk;
      exp_edge    = 0;
      exp_bit_vld = 1'b0;
      chk_state   = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit b2b_prev;
    int p;
    bit pe, gl, perr, serr;
    logic [7:0] d;

    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3, 1'b0);

    // Parity frame, clean.
    send_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(3, 1'b1);
    // No parity, prescale 16.
    send_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(3, 1'b1);
    // Start glitch: line low two cycles only.
    send_frame(8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    idle(4, 1'b0);
    // Parity error suppresses data_valid.
    send_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(3, 1'b1);
    // Held par_err=1 from the last frame must be ignored without parity.
    send_frame(8, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(3, 1'b1);
    // Stop error.
    send_frame(10, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(3, 1'b1);
    // Back-to-back frames.
    send_frame(8, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(3, 1'b1);
    // Reset at cycle 40 of a frame.
    send_frame(8, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 40);
    @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b1;
    idle(12, 1'b0);

    // Randomized frames, including boundary prescales and back-to-back runs.
    b2b_prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      p    = (i == 0) ? 32 : 2 * $urandom_range(4, 16);
      pe   = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      gl   = ($urandom_range(0, 7) == 0);
      perr = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 3) == 0);
      send_frame(p, pe, d, gl, perr, serr, b2b_prev, -1);
      if (gl) begin
        b2b_prev = 1'b0;
        idle(2, 1'b0);
      end else if ($urandom_range(0, 2) == 0) begin
        b2b_prev = 1'b1;
      end else begin
        b2b_prev = 1'b0;
        idle(3, 1'b1);
      end
    end
    if (b2b_prev) idle(3, 1'b1);

    idle(2, 1'b0);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART RX path. Detects a start bit on the oversampled serial line and tracks edge and bit position within the frame. Issues one-cycle enable strobes to the data sampler, deserializer, start/parity/stop checkers, then flags a clean frame with data_valid. It sits directly upstream of the parity checker, driving its par_chk_en and consuming its par_err.

Parameters:
Data_Width, 8, number of data bits per frame (LSB first)
Pre_Width, 6, width of the prescale input and edge counter

Ports:
clk  input  1  RX oversampling clock
rst  input  1  asynchronous active-low reset
rx_in  input  1  serial line, idle high, synchronized upstream
prescale  input  Pre_Width  oversampling ratio; legal values are even and 8..32
par_en  input  1  1 = frame carries a parity bit
par_err  input  1  registered result from parity checker, valid cycle after par_chk_en
strt_glitch  input  1  registered result from start checker, valid cycle after strt_chk_en
stp_err  input  1  registered result from stop checker, valid cycle after stp_chk_en
dat_samp_en  output  1  data sampler enable
edge_cnt  output  Pre_Width  edge index within current bit, 0..prescale-1
bit_cnt  output  4  data bit index, 0..Data_Width-1
deser_en  output  1  deserializer shift strobe
strt_chk_en  output  1  start-check strobe
par_chk_en  output  1  parity-check strobe
stp_chk_en  output  1  stop-check strobe
data_valid  output  1  one-cycle pulse, frame error-free
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=0): state IDLE; edge_cnt=0, bit_cnt=0; all strobes, data_valid, dat_samp_en, busy = 0. Reset mid-frame aborts silently, no data_valid.
- prescale and par_en latched on the IDLE->START transition; changes mid-frame are ignored until the next frame.
- Definitions: P = latched prescale; C = P/2+2 (check edge, after samples at P/2-1, P/2, P/2+1); L = P-1 (last edge).
- edge_cnt increments every cycle outside IDLE and wraps L->0. bit_cnt increments at the L edge in DATA only and resets to 0 on entering DATA.
- All outputs are decoded from registered state and counters. There is no combinational path from rx_in to any output.
- IDLE: rx_in==0 for one cycle (detection cycle = edge 0) -> START with edge_cnt=1. Otherwise stay.
- START: strt_chk_en=1 when edge_cnt==C. At edge L: strt_glitch=1 -> IDLE (edge_cnt=0); else -> DATA with bit_cnt=0.
- DATA: deser_en=1 when edge_cnt==C. At edge L with bit_cnt==Data_Width-1: -> PARITY if latched par_en, else STOP.
- PARITY: par_chk_en=1 when edge_cnt==C. At edge L -> STOP.
- STOP: stp_chk_en=1 when edge_cnt==C. At edge L -> ERR_CHK.
- ERR_CHK (one cycle): data_valid = ~(par_err | stp_err). par_err is ignored when par_en=0. Next state is START if rx_in==0 (back-to-back; this cycle counts as edge 0, so START begins at edge_cnt=1), else IDLE.
- dat_samp_en and busy are high in START, DATA, PARITY, STOP, ERR_CHK.
- Each strobe is exactly one cycle per bit. Strobes never overlap.
- Frame length in cycles from the detection cycle (cycle 0): data_valid asserts at cycle P*(Data_Width+2+par_en).
- par_err/stp_err are sampled only in ERR_CHK. Values from a previous frame have no effect.
- Start glitch: no data_valid, no deser_en, no par/stp strobes for that frame.

Test Plan:
- prescale=8, par_en=1, frame 0xA5 with even parity, checkers return 0 -> 8 deser_en pulses at cycles 14,22,...,70; par_chk_en at 78; stp_chk_en at 86; data_valid=1 at cycle 88 only.
- prescale=16, par_en=0, frame 0x3C -> no par_chk_en; stp_chk_en at cycle 154; data_valid at cycle 160; bit_cnt steps 0..7.
- prescale=8, rx_in low for 2 cycles only, strt_glitch=1 at cycle 7 -> IDLE at cycle 8; no deser_en, no data_valid; busy low from cycle 8.
- prescale=8, par_en=1, par_err=1 at cycle 79 -> data_valid stays 0 at cycle 88; FSM returns to IDLE.
- Two back-to-back frames, rx_in=0 during ERR_CHK (cycle 88) -> second frame's START begins at cycle 89 with edge_cnt=1; second data_valid at cycle 176.
- Assert rst at cycle 40 of a prescale=8 frame -> all outputs 0 immediately. After release, rx_in high keeps the block in IDLE with no data_valid.
